// File: rtl/jtag_user_pkg.sv
// Shared constants for the USER1 command chain: scan widths, function codes
// and the header/data phase encoding.
package jtag_user_pkg;

  localparam int unsigned FUNC_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 5;

  localparam logic [FUNC_W-1:0] F_NOP       = 8'h00;
  localparam logic [FUNC_W-1:0] F_WR_CTRL   = 8'h01;
  localparam logic [FUNC_W-1:0] F_RD_CTRL   = 8'h02;
  localparam logic [FUNC_W-1:0] F_RD_STATUS = 8'h03;
  localparam logic [FUNC_W-1:0] F_RESYNC    = 8'h04;
  localparam logic [FUNC_W-1:0] F_WR_DELAY  = 8'h05;

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_DATA = 1'b1
  } state_t;

endpackage

// File: rtl/jtag_user_sr.sv
// USER1 data shift register with preload mux input and saturating bit counter.
// Ports:
//   tck, rst          clock, async active-high reset
//   shift_en          shift sdi in at the MSB (LSB-first scan)
//   load_en           load load_val and clear the counter
//   sdi, load_val     serial in, parallel preload value
//   sr, count         register contents, bits shifted since last preload
module jtag_user_sr
  import jtag_user_pkg::*;
#(
  parameter int unsigned SR_W = 16
) (
  input  logic             tck,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             load_en,
  input  logic             sdi,
  input  logic [SR_W-1:0]  load_val,
  output logic [SR_W-1:0]  sr,
  output logic [CNT_W-1:0] count
);

  // Preload and shift are mutually exclusive by construction in the parent.
  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      sr    <= '0;
      count <= '0;
    end else if (load_en) begin
      sr    <= load_val;
      count <= '0;
    end else if (shift_en) begin
      sr <= {sdi, sr[SR_W-1:1]};
      if (count != '1) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jtag_user1_cmd.sv
// USER1 chain command decoder: header scan selects a function, optional data
// scan reads or writes CTRL / DELAY / STATUS, RESYNC is a one-cycle pulse.
// Ports:
//   TCK, RST                clock, async active-high reset
//   SEL1, SHIFT, UPDATE     BSCAN state decodes (change on negedge TCK)
//   BTDI, TDO1              serial in, serial out (= sr[0])
//   STATUS                  read-only status word captured at preload
//   CTRL, DELAY             control register, delay setting
//   RESYNC                  one-TCK pulse
//   FUNC                    last correctly sized header
//   DATA_MODE               next DR scan is a data scan
//   LEN_ERR                 sticky wrong-length flag
module jtag_user1_cmd #(
  parameter int unsigned       FUNC_W   = 8,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [DATA_W-1:0] CTRL_RST = '0
) (
  input  logic              TCK,
  input  logic              RST,
  input  logic              SEL1,
  input  logic              SHIFT,
  input  logic              UPDATE,
  input  logic              BTDI,
  input  logic [DATA_W-1:0] STATUS,
  output logic              TDO1,
  output logic [DATA_W-1:0] CTRL,
  output logic [5:0]        DELAY,
  output logic              RESYNC,
  output logic [FUNC_W-1:0] FUNC,
  output logic              DATA_MODE,
  output logic              LEN_ERR
);

  import jtag_user_pkg::*;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sr;
  logic [CNT_W-1:0]    count;
  logic [DATA_W-1:0]   preload_val;
  logic [FUNC_W-1:0]   hdr_code;
  logic                shift_en, load_en;
  logic                hdr_len_ok, data_len_ok;
  logic                func_we, ctrl_we, delay_we, resync_d, len_set, len_clr;

  // UPDATE wins over SHIFT if both are ever seen together.
  assign shift_en    = SEL1 & SHIFT & ~UPDATE;
  assign load_en     = SEL1 & ~SHIFT & ~UPDATE;
  assign hdr_code    = sr[DATA_W-1 -: FUNC_W];
  assign hdr_len_ok  = (count == CNT_W'(FUNC_W));
  assign data_len_ok = (count == CNT_W'(DATA_W));
  assign TDO1        = sr[0];
  assign DATA_MODE   = (state_q == ST_DATA);

  jtag_user_sr #(
    .SR_W (DATA_W)
  ) u_sr (
    .tck      (TCK),
    .rst      (RST),
    .shift_en (shift_en),
    .load_en  (load_en),
    .sdi      (BTDI),
    .load_val (preload_val),
    .sr       (sr),
    .count    (count)
  );

  // Read-back source for the data scan; headers always shift out zeros.
  always_comb begin
    preload_val = '0;
    if (state_q == ST_DATA) begin
      if (FUNC == F_RD_CTRL)        preload_val = CTRL;
      else if (FUNC == F_RD_STATUS) preload_val = STATUS;
    end
  end

  // Phase sequencing and update-time decode.
  always_comb begin
    state_d  = state_q;
    func_we  = 1'b0;
    ctrl_we  = 1'b0;
    delay_we = 1'b0;
    resync_d = 1'b0;
    len_set  = 1'b0;
    len_clr  = 1'b0;
    if (!SEL1) begin
      state_d = ST_HDR;
    end else if (UPDATE) begin
      if (state_q == ST_HDR) begin
        if (hdr_len_ok) begin
          func_we = 1'b1;
          case (hdr_code)
            F_WR_CTRL, F_RD_CTRL, F_RD_STATUS, F_WR_DELAY: state_d = ST_DATA;
            F_RESYNC: resync_d = 1'b1;
            default: ;
          endcase
        end else begin
          len_set = 1'b1;
        end
      end else begin
        state_d = ST_HDR;
        if (data_len_ok) begin
          case (FUNC)
            F_WR_CTRL:   ctrl_we  = 1'b1;
            F_WR_DELAY:  delay_we = 1'b1;
            F_RD_STATUS: len_clr  = 1'b1;
            default: ;
          endcase
        end else begin
          len_set = 1'b1;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      state_q <= ST_HDR;
      CTRL    <= CTRL_RST;
      DELAY   <= '0;
      FUNC    <= '0;
      RESYNC  <= 1'b0;
      LEN_ERR <= 1'b0;
    end else begin
      state_q <= state_d;
      RESYNC  <= resync_d;
      if (func_we)  FUNC  <= hdr_code;
      if (ctrl_we)  CTRL  <= sr;
      if (delay_we) DELAY <= sr[5:0];
      if (len_set)      LEN_ERR <= 1'b1;
      else if (len_clr) LEN_ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_user1_cmd.sv
// Directed bench for jtag_user1_cmd: drives BSCAN-style scans on negedge TCK
// and checks outputs against hand-computed values.
module tb_jtag_user1_cmd;

  logic        tck = 1'b0;
  logic        rst, sel1, shift, update, btdi;
  logic [15:0] status;
  logic        tdo1, resync, data_mode, len_err;
  logic [15:0] ctrl;
  logic [5:0]  delay;
  logic [7:0]  func;

  int total = 0;
  int bad   = 0;

  always #5 tck = ~tck;

  jtag_user1_cmd dut (
    .TCK       (tck),
    .RST       (rst),
    .SEL1      (sel1),
    .SHIFT     (shift),
    .UPDATE    (update),
    .BTDI      (btdi),
    .STATUS    (status),
    .TDO1      (tdo1),
    .CTRL      (ctrl),
    .DELAY     (delay),
    .RESYNC    (resync),
    .FUNC      (func),
    .DATA_MODE (data_mode),
    .LEN_ERR   (len_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preload();
    @(negedge tck);
    sel1 = 1'b1; shift = 1'b0; update = 1'b0;
  endtask

  task automatic shift_bit(input logic b, output logic t);
    @(negedge tck);
    t = tdo1;
    shift = 1'b1; btdi = b;
  endtask

  // Ends on the negedge following the update posedge.
  task automatic do_update();
    @(negedge tck);
    shift = 1'b0; update = 1'b1;
    @(negedge tck);
    update = 1'b0;
  endtask

  task automatic scan(input int n, input logic [15:0] val, output logic [15:0] rd);
    logic t;
    rd = '0;
    preload();
    for (int i = 0; i < n; i++) begin
      shift_bit(val[i], t);
      rd[i] = t;
    end
    do_update();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd;
    logic        t;
    rst = 1'b1; sel1 = 1'b0; shift = 1'b0; update = 1'b0; btdi = 1'b0;
    status = 16'h5A3C;
    #2;
    chk("rst_tdo1",   32'(tdo1),      32'h0);
    chk("rst_ctrl",   32'(ctrl),      32'h0);
    chk("rst_delay",  32'(delay),     32'h0);
    chk("rst_func",   32'(func),      32'h0);
    chk("rst_resync", 32'(resync),    32'h0);
    chk("rst_dmode",  32'(data_mode), 32'h0);
    chk("rst_lenerr", 32'(len_err),   32'h0);
    @(negedge tck); rst = 1'b0;

    // write CTRL
    scan(8, 16'h0001, rd);
    chk("wr_hdr_dmode", 32'(data_mode), 32'h1);
    chk("wr_hdr_func",  32'(func),      32'h01);
    scan(16, 16'hA5C3, rd);
    chk("wr_ctrl",      32'(ctrl),      32'hA5C3);
    chk("wr_dmode",     32'(data_mode), 32'h0);
    chk("wr_lenerr",    32'(len_err),   32'h0);

    // read CTRL back LSB-first
    scan(8, 16'h0002, rd);
    scan(16, 16'h0000, rd);
    chk("rd_ctrl_tdo",  32'(rd),   32'hA5C3);
    chk("rd_ctrl_keep", 32'(ctrl), 32'hA5C3);

    // resync pulse
    scan(8, 16'h0004, rd);
    chk("resync_hi",    32'(resync),    32'h1);
    chk("resync_dmode", 32'(data_mode), 32'h0);
    @(negedge tck);
    chk("resync_lo",    32'(resync),    32'h0);

    // delay write uses low 6 bits
    scan(8, 16'h0005, rd);
    scan(16, 16'hFFEA, rd);
    chk("wr_delay",     32'(delay), 32'h2A);
    chk("wr_delay_ctl", 32'(ctrl),  32'hA5C3);

    // short data scan
    scan(8, 16'h0001, rd);
    scan(15, 16'h1234, rd);
    chk("short_ctrl",   32'(ctrl),      32'hA5C3);
    chk("short_lenerr", 32'(len_err),   32'h1);
    chk("short_dmode",  32'(data_mode), 32'h0);

    // short header: FUNC kept, stays in header phase
    scan(7, 16'h0003, rd);
    chk("shdr_func",    32'(func),      32'h01);
    chk("shdr_dmode",   32'(data_mode), 32'h0);
    chk("shdr_lenerr",  32'(len_err),   32'h1);

    // status read clears LEN_ERR
    scan(8, 16'h0003, rd);
    scan(16, 16'h0000, rd);
    chk("rd_status",    32'(rd),      32'h5A3C);
    chk("st_lenerr",    32'(len_err), 32'h0);

    // SEL1 drop aborts pending data phase
    scan(8, 16'h0001, rd);
    chk("abort_pre",    32'(data_mode), 32'h1);
    @(negedge tck); sel1 = 1'b0;
    @(negedge tck);
    chk("abort_dmode",  32'(data_mode), 32'h0);
    chk("abort_func",   32'(func),      32'h01);
    sel1 = 1'b1;
    scan(8, 16'h0002, rd);
    chk("abort_hdr",    32'(func),      32'h02);
    chk("abort_hdr_dm", 32'(data_mode), 32'h1);
    scan(16, 16'h0000, rd);
    chk("abort_rd",     32'(rd),   32'hA5C3);

    // reset in the middle of a data scan
    scan(8, 16'h0001, rd);
    preload();
    for (int i = 0; i < 8; i++) shift_bit(1'((16'h12F0 >> i) & 16'h1), t);
    @(negedge tck);
    rst = 1'b1; shift = 1'b0;
    #1;
    chk("mrst_ctrl",    32'(ctrl),      32'h0);
    chk("mrst_delay",   32'(delay),     32'h0);
    chk("mrst_func",    32'(func),      32'h0);
    chk("mrst_dmode",   32'(data_mode), 32'h0);
    chk("mrst_tdo1",    32'(tdo1),      32'h0);
    @(negedge tck); rst = 1'b0;
    preload();
    for (int i = 8; i < 16; i++) shift_bit(1'((16'h12F0 >> i) & 16'h1), t);
    do_update();
    chk("mrst_nowrite", 32'(ctrl),      32'h0);
    chk("mrst_hdr",     32'(func),      32'h12);
    chk("mrst_dmode2",  32'(data_mode), 32'h0);
    chk("mrst_lenerr",  32'(len_err),   32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
